ysyx_25040109_axi_arbiter: RTL and testbench

//  Two-master to one-slave AXI4 arbiter in front of the address-decode crossbar.

---
 rtl/ysyx_25040109_axi_pkg.sv | 9 +
 rtl/ysyx_25040109_rr_arb2.sv | 13 +
 rtl/ysyx_25040109_axi_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_ysyx_25040109_axi_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040109_axi_pkg.sv
// ysyx_25040109_axi_pkg: shared AXI encodings and arbiter state type
package ysyx_25040109_axi_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_4B     = 3'b010;
  typedef enum logic [2:0] {S_IDLE, S_ARB, S_RADDR, S_RDATA, S_WADDR, S_WRESP} arb_state_e;
endpackage

// File: rtl/ysyx_25040109_rr_arb2.sv
// ysyx_25040109_rr_arb2: two-request round-robin picker; ptr_i=1 favours requester 1
module ysyx_25040109_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  input  logic       adv_i,
  input  logic       last_i,
  output logic [1:0] gnt_o,
  output logic       ptr_o
);
  assign gnt_o = ptr_i ? (req_i[1] ? 2'b10 : {1'b0, req_i[0]})
                       : (req_i[0] ? 2'b01 : {req_i[1], 1'b0});
  assign ptr_o = adv_i ? ~last_i : ptr_i;
endmodule

// File: rtl/ysyx_25040109_axi_arbiter.sv
// ysyx_25040109_axi_arbiter: IFU(M0)/LSU(M1) to one AXI slave, whole-transaction round-robin grant.
// Define ARB_PERF_EN to add the perf_* transaction and wait counters.
module ysyx_25040109_axi_arbiter
  import ysyx_25040109_axi_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int IDW    = 4,
  parameter int PERF_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_arvalid_i,
  output logic            ifu_arready_o,
  input  logic [AW-1:0]   ifu_araddr_i,
  input  logic [IDW-1:0]  ifu_arid_i,
  input  logic [7:0]      ifu_arlen_i,
  input  logic [2:0]      ifu_arsize_i,
  input  logic [1:0]      ifu_arburst_i,
  output logic            ifu_rvalid_o,
  input  logic            ifu_rready_i,
  output logic [DW-1:0]   ifu_rdata_o,
  output logic [1:0]      ifu_rresp_o,
  output logic [IDW-1:0]  ifu_rid_o,
  output logic            ifu_rlast_o,
  input  logic            lsu_arvalid_i,
  output logic            lsu_arready_o,
  input  logic [AW-1:0]   lsu_araddr_i,
  input  logic [IDW-1:0]  lsu_arid_i,
  input  logic [7:0]      lsu_arlen_i,
  input  logic [2:0]      lsu_arsize_i,
  input  logic [1:0]      lsu_arburst_i,
  output logic            lsu_rvalid_o,
  input  logic            lsu_rready_i,
  output logic [DW-1:0]   lsu_rdata_o,
  output logic [1:0]      lsu_rresp_o,
  output logic [IDW-1:0]  lsu_rid_o,
  output logic            lsu_rlast_o,
  input  logic            lsu_awvalid_i,
  output logic            lsu_awready_o,
  input  logic [AW-1:0]   lsu_awaddr_i,
  input  logic [IDW-1:0]  lsu_awid_i,
  input  logic [7:0]      lsu_awlen_i,
  input  logic [2:0]      lsu_awsize_i,
  input  logic [1:0]      lsu_awburst_i,
  input  logic            lsu_wvalid_i,
  output logic            lsu_wready_o,
  input  logic [DW-1:0]   lsu_wdata_i,
  input  logic [DW/8-1:0] lsu_wstrb_i,
  input  logic            lsu_wlast_i,
  output logic            lsu_bvalid_o,
  input  logic            lsu_bready_i,
  output logic [1:0]      lsu_bresp_o,
  output logic [IDW-1:0]  lsu_bid_o,
  output logic            out_arvalid_o,
  input  logic            out_arready_i,
  output logic [AW-1:0]   out_araddr_o,
  output logic [IDW-1:0]  out_arid_o,
  output logic [7:0]      out_arlen_o,
  output logic [2:0]      out_arsize_o,
  output logic [1:0]      out_arburst_o,
  input  logic            out_rvalid_i,
  output logic            out_rready_o,
  input  logic [DW-1:0]   out_rdata_i,
  input  logic [1:0]      out_rresp_i,
  input  logic [IDW-1:0]  out_rid_i,
  input  logic            out_rlast_i,
  output logic            out_awvalid_o,
  input  logic            out_awready_i,
  output logic [AW-1:0]   out_awaddr_o,
  output logic [IDW-1:0]  out_awid_o,
  output logic [7:0]      out_awlen_o,
  output logic [2:0]      out_awsize_o,
  output logic [1:0]      out_awburst_o,
  output logic            out_wvalid_o,
  input  logic            out_wready_i,
  output logic [DW-1:0]   out_wdata_o,
  output logic [DW/8-1:0] out_wstrb_o,
  output logic            out_wlast_o,
  input  logic            out_bvalid_i,
  output logic            out_bready_o,
  input  logic [1:0]      out_bresp_i,
  input  logic [IDW-1:0]  out_bid_i
`ifdef ARB_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_ifu_txn,
  output logic [PERF_W-1:0] perf_lsu_txn,
  output logic [PERF_W-1:0] perf_wait
`endif
);
  arb_state_e state_q, state_d;
  logic gnt_q, gnt_d, wr_q, wr_d, ptr_q, ptr_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic adv, aw_now, w_now;
  logic [1:0] req, pick;
  assign req = {lsu_arvalid_i | lsu_awvalid_i, ifu_arvalid_i};
  ysyx_25040109_rr_arb2 u_rr (
    .req_i(req), .ptr_i(ptr_q), .adv_i(adv), .last_i(gnt_q), .gnt_o(pick), .ptr_o(ptr_d)
  );
  wire in_raddr = state_q == S_RADDR;
  wire in_rdata = state_q == S_RDATA;
  wire in_waddr = state_q == S_WADDR;
  wire in_wresp = state_q == S_WRESP;
  assign out_arvalid_o = in_raddr & (gnt_q ? lsu_arvalid_i : ifu_arvalid_i);
  assign ifu_arready_o = in_raddr & ~gnt_q & out_arready_i;
  assign lsu_arready_o = in_raddr & gnt_q & out_arready_i;
  assign out_araddr_o  = gnt_q ? lsu_araddr_i : ifu_araddr_i;
  assign out_arid_o    = gnt_q ? lsu_arid_i : ifu_arid_i;
  assign out_arlen_o   = gnt_q ? lsu_arlen_i : ifu_arlen_i;
  assign out_arsize_o  = gnt_q ? lsu_arsize_i : ifu_arsize_i;
  assign out_arburst_o = gnt_q ? lsu_arburst_i : ifu_arburst_i;
  assign out_rready_o  = in_rdata & (gnt_q ? lsu_rready_i : ifu_rready_i);
  assign ifu_rvalid_o  = in_rdata & ~gnt_q & out_rvalid_i;
  assign lsu_rvalid_o  = in_rdata & gnt_q & out_rvalid_i;
  assign ifu_rdata_o = out_rdata_i;
  assign ifu_rresp_o = out_rresp_i;
  assign ifu_rid_o   = out_rid_i;
  assign ifu_rlast_o = out_rlast_i;
  assign lsu_rdata_o = out_rdata_i;
  assign lsu_rresp_o = out_rresp_i;
  assign lsu_rid_o   = out_rid_i;
  assign lsu_rlast_o = out_rlast_i;
  // AW and W run independently; each is masked once its own handshake is done
  assign out_awvalid_o = in_waddr & ~aw_done_q & lsu_awvalid_i;
  assign lsu_awready_o = in_waddr & ~aw_done_q & out_awready_i;
  assign out_wvalid_o  = in_waddr & ~w_done_q & lsu_wvalid_i;
  assign lsu_wready_o  = in_waddr & ~w_done_q & out_wready_i;
  assign out_awaddr_o  = lsu_awaddr_i;
  assign out_awid_o    = lsu_awid_i;
  assign out_awlen_o   = lsu_awlen_i;
  assign out_awsize_o  = lsu_awsize_i;
  assign out_awburst_o = lsu_awburst_i;
  assign out_wdata_o   = lsu_wdata_i;
  assign out_wstrb_o   = lsu_wstrb_i;
  assign out_wlast_o   = lsu_wlast_i;
  assign out_bready_o  = in_wresp & lsu_bready_i;
  assign lsu_bvalid_o  = in_wresp & out_bvalid_i;
  assign lsu_bresp_o   = out_bresp_i;
  assign lsu_bid_o     = out_bid_i;
  assign aw_now = aw_done_q | (out_awvalid_o & out_awready_i);
  assign w_now  = w_done_q | (out_wvalid_o & out_wready_i & lsu_wlast_i);
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    wr_d      = wr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    adv       = 1'b0;
    case (state_q)
      S_IDLE: if (|req) begin
        state_d = S_ARB;
        gnt_d   = pick[1];
        wr_d    = pick[1] & lsu_awvalid_i;
      end
      S_ARB:   state_d = wr_q ? S_WADDR : S_RADDR;
      S_RADDR: state_d = (out_arvalid_o & out_arready_i) ? S_RDATA : S_RADDR;
      S_RDATA: if (out_rvalid_i & out_rready_o & out_rlast_i) begin
        state_d = S_IDLE;
        adv     = 1'b1;
      end
      S_WADDR: begin
        state_d   = (aw_now & w_now) ? S_WRESP : S_WADDR;
        aw_done_d = aw_now & ~w_now;
        w_done_d  = w_now & ~aw_now;
      end
      S_WRESP: if (out_bvalid_i & out_bready_o) begin
        state_d = S_IDLE;
        adv     = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= 1'b0;
      wr_q      <= 1'b0;
      ptr_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      wr_q      <= wr_d;
      ptr_q     <= ptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
`ifdef ARB_PERF_EN
  logic [PERF_W-1:0] ifu_txn_q, lsu_txn_q, wait_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifu_txn_q <= '0;
      lsu_txn_q <= '0;
      wait_q    <= '0;
    end else begin
      ifu_txn_q <= ifu_txn_q + PERF_W'(adv & ~gnt_q);
      lsu_txn_q <= lsu_txn_q + PERF_W'(adv & gnt_q);
      wait_q    <= wait_q + PERF_W'((state_q != S_IDLE) & (gnt_q ? req[0] : req[1]));
    end
  end
  assign perf_ifu_txn = ifu_txn_q;
  assign perf_lsu_txn = lsu_txn_q;
  assign perf_wait    = wait_q;
`endif
endmodule

// File: tb/tb_ysyx_25040109_axi_arbiter.sv
// tb_ysyx_25040109_axi_arbiter: directed vectors for the IFU/LSU AXI arbiter (ARB_PERF_EN optional)
module tb_ysyx_25040109_axi_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  int vec = 0, bad = 0;
  logic ifu_arvalid_i, ifu_arready_o, ifu_rvalid_o, ifu_rready_i, ifu_rlast_o;
  logic [31:0] ifu_araddr_i, ifu_rdata_o;
  logic [3:0] ifu_arid_i, ifu_rid_o;
  logic [7:0] ifu_arlen_i;
  logic [2:0] ifu_arsize_i;
  logic [1:0] ifu_arburst_i, ifu_rresp_o;
  logic lsu_arvalid_i, lsu_arready_o, lsu_rvalid_o, lsu_rready_i, lsu_rlast_o;
  logic [31:0] lsu_araddr_i, lsu_rdata_o;
  logic [3:0] lsu_arid_i, lsu_rid_o;
  logic [7:0] lsu_arlen_i;
  logic [2:0] lsu_arsize_i;
  logic [1:0] lsu_arburst_i, lsu_rresp_o;
  logic lsu_awvalid_i, lsu_awready_o, lsu_wvalid_i, lsu_wready_o, lsu_wlast_i, lsu_bvalid_o, lsu_bready_i;
  logic [31:0] lsu_awaddr_i, lsu_wdata_i;
  logic [3:0] lsu_awid_i, lsu_bid_o, lsu_wstrb_i;
  logic [7:0] lsu_awlen_i;
  logic [2:0] lsu_awsize_i;
  logic [1:0] lsu_awburst_i, lsu_bresp_o;
  logic out_arvalid_o, out_arready_i, out_rvalid_i, out_rready_o, out_rlast_i;
  logic [31:0] out_araddr_o, out_rdata_i;
  logic [3:0] out_arid_o, out_rid_i;
  logic [7:0] out_arlen_o;
  logic [2:0] out_arsize_o;
  logic [1:0] out_arburst_o, out_rresp_i;
  logic out_awvalid_o, out_awready_i, out_wvalid_o, out_wready_i, out_wlast_o, out_bvalid_i, out_bready_o;
  logic [31:0] out_awaddr_o, out_wdata_o;
  logic [3:0] out_awid_o, out_bid_i, out_wstrb_o;
  logic [7:0] out_awlen_o;
  logic [2:0] out_awsize_o;
  logic [1:0] out_awburst_o, out_bresp_i;
`ifdef ARB_PERF_EN
  logic [31:0] perf_ifu_txn, perf_lsu_txn, perf_wait;
`endif
  ysyx_25040109_axi_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_arvalid_i(ifu_arvalid_i), .ifu_arready_o(ifu_arready_o), .ifu_araddr_i(ifu_araddr_i),
    .ifu_arid_i(ifu_arid_i), .ifu_arlen_i(ifu_arlen_i), .ifu_arsize_i(ifu_arsize_i),
    .ifu_arburst_i(ifu_arburst_i), .ifu_rvalid_o(ifu_rvalid_o), .ifu_rready_i(ifu_rready_i),
    .ifu_rdata_o(ifu_rdata_o), .ifu_rresp_o(ifu_rresp_o), .ifu_rid_o(ifu_rid_o), .ifu_rlast_o(ifu_rlast_o),
    .lsu_arvalid_i(lsu_arvalid_i), .lsu_arready_o(lsu_arready_o), .lsu_araddr_i(lsu_araddr_i),
    .lsu_arid_i(lsu_arid_i), .lsu_arlen_i(lsu_arlen_i), .lsu_arsize_i(lsu_arsize_i),
    .lsu_arburst_i(lsu_arburst_i), .lsu_rvalid_o(lsu_rvalid_o), .lsu_rready_i(lsu_rready_i),
    .lsu_rdata_o(lsu_rdata_o), .lsu_rresp_o(lsu_rresp_o), .lsu_rid_o(lsu_rid_o), .lsu_rlast_o(lsu_rlast_o),
    .lsu_awvalid_i(lsu_awvalid_i), .lsu_awready_o(lsu_awready_o), .lsu_awaddr_i(lsu_awaddr_i),
    .lsu_awid_i(lsu_awid_i), .lsu_awlen_i(lsu_awlen_i), .lsu_awsize_i(lsu_awsize_i),
    .lsu_awburst_i(lsu_awburst_i), .lsu_wvalid_i(lsu_wvalid_i), .lsu_wready_o(lsu_wready_o),
    .lsu_wdata_i(lsu_wdata_i), .lsu_wstrb_i(lsu_wstrb_i), .lsu_wlast_i(lsu_wlast_i),
    .lsu_bvalid_o(lsu_bvalid_o), .lsu_bready_i(lsu_bready_i), .lsu_bresp_o(lsu_bresp_o), .lsu_bid_o(lsu_bid_o),
    .out_arvalid_o(out_arvalid_o), .out_arready_i(out_arready_i), .out_araddr_o(out_araddr_o),
    .out_arid_o(out_arid_o), .out_arlen_o(out_arlen_o), .out_arsize_o(out_arsize_o),
    .out_arburst_o(out_arburst_o), .out_rvalid_i(out_rvalid_i), .out_rready_o(out_rready_o),
    .out_rdata_i(out_rdata_i), .out_rresp_i(out_rresp_i), .out_rid_i(out_rid_i), .out_rlast_i(out_rlast_i),
    .out_awvalid_o(out_awvalid_o), .out_awready_i(out_awready_i), .out_awaddr_o(out_awaddr_o),
    .out_awid_o(out_awid_o), .out_awlen_o(out_awlen_o), .out_awsize_o(out_awsize_o),
    .out_awburst_o(out_awburst_o), .out_wvalid_o(out_wvalid_o), .out_wready_i(out_wready_i),
    .out_wdata_o(out_wdata_o), .out_wstrb_o(out_wstrb_o), .out_wlast_o(out_wlast_o),
    .out_bvalid_i(out_bvalid_i), .out_bready_o(out_bready_o), .out_bresp_i(out_bresp_i), .out_bid_i(out_bid_i)
`ifdef ARB_PERF_EN
    , .perf_ifu_txn(perf_ifu_txn), .perf_lsu_txn(perf_lsu_txn), .perf_wait(perf_wait)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    vec++;
    if (o !== e) begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic serve_read(input logic m, input logic [31:0] addr, input logic [7:0] len, input logic [31:0] d0);
    int n = 0;
    logic last;
    #1;
    while (!out_arvalid_o && n < 20) begin
      tick();
      n++;
    end
    chk("ar_wait", out_arvalid_o, 1'b1);
    chk("out_araddr", out_araddr_o, addr);
    chk("out_arlen", out_arlen_o, len);
    out_arready_i = 1'b1;
    #1;
    chk("gnt_arready", (m ? lsu_arready_o : ifu_arready_o), 1'b1);
    chk("oth_arready", (m ? ifu_arready_o : lsu_arready_o), 1'b0);
    tick();
    if (m) lsu_arvalid_i = 1'b0; else ifu_arvalid_i = 1'b0;
    out_arready_i = 1'b0;
    ifu_rready_i = ~m;
    lsu_rready_i = m;
    for (int i = 0; i <= int'(len); i++) begin
      last = (i == int'(len));
      out_rvalid_i = 1'b1;
      out_rdata_i = d0 + 32'(i);
      out_rlast_i = last;
      #1;
      chk("gnt_rvalid", (m ? lsu_rvalid_o : ifu_rvalid_o), 1'b1);
      chk("oth_rvalid", (m ? ifu_rvalid_o : lsu_rvalid_o), 1'b0);
      chk("gnt_rdata", (m ? lsu_rdata_o : ifu_rdata_o), d0 + 32'(i));
      chk("gnt_rlast", (m ? lsu_rlast_o : ifu_rlast_o), last);
      chk("out_rready", out_rready_o, 1'b1);
      chk("no_ar_in_r", out_arvalid_o, 1'b0);
      tick();
    end
    out_rvalid_i = 1'b0;
    out_rlast_i = 1'b0;
    ifu_rready_i = 1'b0;
    lsu_rready_i = 1'b0;
  endtask
  task automatic serve_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb, input int wlag);
    int n = 0;
    #1;
    while (!out_awvalid_o && n < 20) begin
      tick();
      n++;
    end
    chk("aw_wait", out_awvalid_o, 1'b1);
    chk("out_awaddr", out_awaddr_o, addr);
    chk("no_ar_in_w", out_arvalid_o, 1'b0);
    out_awready_i = 1'b1;
    #1;
    chk("lsu_awready", lsu_awready_o, 1'b1);
    tick();
    lsu_awvalid_i = 1'b0;
    out_awready_i = 1'b0;
    for (int i = 0; i < wlag; i++) begin
      chk("wvalid_idle", out_wvalid_o, 1'b0);
      tick();
    end
    lsu_wvalid_i = 1'b1;
    lsu_wdata_i = data;
    lsu_wstrb_i = strb;
    lsu_wlast_i = 1'b1;
    out_wready_i = 1'b1;
    #1;
    chk("out_wvalid", out_wvalid_o, 1'b1);
    chk("out_wdata", out_wdata_o, data);
    chk("out_wstrb", out_wstrb_o, strb);
    chk("lsu_wready", lsu_wready_o, 1'b1);
    tick();
    lsu_wvalid_i = 1'b0;
    out_wready_i = 1'b0;
    out_bvalid_i = 1'b1;
    out_bresp_i = 2'b00;
    lsu_bready_i = 1'b1;
    #1;
    chk("lsu_bvalid", lsu_bvalid_o, 1'b1);
    chk("out_bready", out_bready_o, 1'b1);
    chk("ifu_held_b", ifu_arready_o, 1'b0);
    chk("no_ar_in_b", out_arvalid_o, 1'b0);
    tick();
    out_bvalid_i = 1'b0;
    lsu_bready_i = 1'b0;
  endtask
  initial begin
    {ifu_arvalid_i, ifu_rready_i, lsu_arvalid_i, lsu_rready_i, lsu_awvalid_i, lsu_wvalid_i, lsu_wlast_i, lsu_bready_i} = '0;
    {out_arready_i, out_rvalid_i, out_rlast_i, out_awready_i, out_wready_i, out_bvalid_i} = '0;
    ifu_araddr_i = '0; lsu_araddr_i = '0; lsu_awaddr_i = '0; lsu_wdata_i = '0; lsu_wstrb_i = '0;
    ifu_arid_i = 4'h1; lsu_arid_i = 4'h2; lsu_awid_i = 4'h3;
    ifu_arlen_i = '0; lsu_arlen_i = '0; lsu_awlen_i = '0;
    ifu_arsize_i = 3'b010; lsu_arsize_i = 3'b010; lsu_awsize_i = 3'b010;
    ifu_arburst_i = 2'b01; lsu_arburst_i = 2'b01; lsu_awburst_i = 2'b01;
    out_rdata_i = '0; out_rresp_i = '0; out_rid_i = '0; out_bresp_i = '0; out_bid_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_arvalid", out_arvalid_o, 1'b0);
    chk("rst_out_awvalid", out_awvalid_o, 1'b0);
    rst = 1'b0;
    ifu_arvalid_i = 1'b1; ifu_araddr_i = 32'h8000_0000; ifu_arlen_i = 8'd0;
    #1;
    chk("t1_idle_arvalid", out_arvalid_o, 1'b0);
    tick();
    chk("t1_arb_arvalid", out_arvalid_o, 1'b0);
    tick();
    chk("t1_2cyc_arvalid", out_arvalid_o, 1'b1);
    chk("t1_arsize", out_arsize_o, 3'b010);
    chk("t1_arid", out_arid_o, 4'h1);
    serve_read(1'b0, 32'h8000_0000, 8'd0, 32'hdead_beef);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifu_arvalid_i = 1'b1; ifu_araddr_i = 32'h8000_0100;
    lsu_arvalid_i = 1'b1; lsu_araddr_i = 32'h2000_0000;
    serve_read(1'b0, 32'h8000_0100, 8'd0, 32'h1111_0000);
    serve_read(1'b1, 32'h2000_0000, 8'd0, 32'h2222_0000);
    ifu_arvalid_i = 1'b1; ifu_araddr_i = 32'h8000_0200; ifu_arlen_i = 8'd1;
    serve_read(1'b0, 32'h8000_0200, 8'd1, 32'h3333_0000);
    ifu_arvalid_i = 1'b1; ifu_araddr_i = 32'h8000_0300; ifu_arlen_i = 8'd0;
    lsu_arvalid_i = 1'b1; lsu_araddr_i = 32'h2000_0010;
    serve_read(1'b1, 32'h2000_0010, 8'd0, 32'h4444_0000);
    serve_read(1'b0, 32'h8000_0300, 8'd0, 32'h5555_0000);
    lsu_awvalid_i = 1'b1; lsu_awaddr_i = 32'h1000_0000;
    ifu_arvalid_i = 1'b1; ifu_araddr_i = 32'h8000_0400;
    serve_write(32'h1000_0000, 32'h0000_0041, 4'b0001, 3);
    serve_read(1'b0, 32'h8000_0400, 8'd0, 32'h6666_0000);
    lsu_arvalid_i = 1'b1; lsu_araddr_i = 32'h2000_0020;
    lsu_awvalid_i = 1'b1; lsu_awaddr_i = 32'h1000_0040;
    lsu_wvalid_i = 1'b1; lsu_wdata_i = 32'h0000_0055; lsu_wstrb_i = 4'b1111; lsu_wlast_i = 1'b1;
    begin
      int n = 0;
      #1;
      while (!out_awvalid_o && n < 20) begin
        tick();
        n++;
      end
    end
    chk("t4_aw_wait", out_awvalid_o, 1'b1);
    chk("t4_no_ar", out_arvalid_o, 1'b0);
    chk("t4_wvalid", out_wvalid_o, 1'b1);
    out_wready_i = 1'b1;
    #1;
    chk("t4_wready", lsu_wready_o, 1'b1);
    chk("t4_awready0", lsu_awready_o, 1'b0);
    tick();
    lsu_wvalid_i = 1'b0; out_wready_i = 1'b0; out_awready_i = 1'b1;
    #1;
    chk("t4_awready1", lsu_awready_o, 1'b1);
    chk("t4_no_b_early", lsu_bvalid_o, 1'b0);
    tick();
    lsu_awvalid_i = 1'b0; out_awready_i = 1'b0; out_bvalid_i = 1'b1; lsu_bready_i = 1'b1;
    #1;
    chk("t4_bvalid", lsu_bvalid_o, 1'b1);
    chk("t4_no_ar_b", out_arvalid_o, 1'b0);
    tick();
    out_bvalid_i = 1'b0; lsu_bready_i = 1'b0;
    serve_read(1'b1, 32'h2000_0020, 8'd0, 32'hcafe_0000);
    ifu_arvalid_i = 1'b1; ifu_araddr_i = 32'h8000_1000; ifu_arlen_i = 8'd3;
    lsu_arvalid_i = 1'b1; lsu_araddr_i = 32'h2000_0030;
    serve_read(1'b0, 32'h8000_1000, 8'd3, 32'h7777_0000);
    serve_read(1'b1, 32'h2000_0030, 8'd0, 32'h8888_0000);
    ifu_arvalid_i = 1'b1; ifu_araddr_i = 32'h8000_2000; ifu_arlen_i = 8'd0;
    begin
      int n = 0;
      #1;
      while (!out_arvalid_o && n < 20) begin
        tick();
        n++;
      end
    end
    out_arready_i = 1'b1;
    tick();
    ifu_arvalid_i = 1'b0; out_arready_i = 1'b0;
    out_rvalid_i = 1'b1; out_rlast_i = 1'b1; ifu_rready_i = 1'b1;
    lsu_arvalid_i = 1'b1; lsu_araddr_i = 32'h2000_0040;
    #1;
    chk("t6_rvalid_pre", ifu_rvalid_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_rst_rvalid", ifu_rvalid_o, 1'b0);
    chk("t6_rst_rready", out_rready_o, 1'b0);
    chk("t6_rst_arvalid", out_arvalid_o, 1'b0);
    chk("t6_rst_lsu_arready", lsu_arready_o, 1'b0);
`ifdef ARB_PERF_EN
    chk("t6_perf_ifu", perf_ifu_txn, 32'd0);
    chk("t6_perf_lsu", perf_lsu_txn, 32'd0);
    chk("t6_perf_wait", perf_wait, 32'd0);
`endif
    tick();
    rst = 1'b0;
    out_rvalid_i = 1'b0; out_rlast_i = 1'b0; ifu_rready_i = 1'b0;
    ifu_arvalid_i = 1'b1; ifu_araddr_i = 32'h8000_3000;
    serve_read(1'b0, 32'h8000_3000, 8'd0, 32'h9999_0000);
    serve_read(1'b1, 32'h2000_0040, 8'd0, 32'haaaa_0000);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
